lsu_mem_ctrl: RTL

Load/store controller between the core's execute stage and `data_mem`. Accepts one load or store per request from the pipeline and runs the full valid/yumi handshake with the data memory. Returns load data to the pipeline and stalls it while a transaction is outstanding. One transaction is in flight at a time.

---
 rtl/lsu_mem_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the execute stage and data_mem.
// One transaction in flight; runs the valid/yumi handshake with the memory and
// returns load data to the pipeline with a one-cycle response pulse.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned word
// accesses locally (error response, no memory transaction).
module lsu_mem_ctrl #(
  parameter int addr_width_p = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid_i,
  input  logic                    req_wen_i,
  input  logic                    req_byte_i,
  input  logic [addr_width_p-1:0] req_addr_i,
  input  logic [31:0]             req_wdata_i,
  output logic                    req_ready_o,
  output logic                    stall_o,
  output logic                    resp_valid_o,
  output logic [31:0]             resp_rdata_o,
  output logic                    resp_err_o,
  output logic [35:0]             mem_flat_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  input  logic [33:0]             mem_flat_i
);

  // Flattened data_mem port layouts (MSB first): 1+1+1+32+1 and 1+32+1 bits.
  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        valid;
    logic [31:0] read_data;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                  state;
  logic                    mem_valid;
  logic                    wen_r;
  logic                    byte_r;
  logic [addr_width_p-1:0] addr_r;
  logic [31:0]             wdata_r;
  logic                    mem_yumi;
  mem_in_s                 mem_in;
  mem_out_s                mem_out;

  assign mem_out = mem_flat_i;

  // The response is consumed in the same cycle it is seen, and only in WAIT;
  // a valid arriving in any other state is a protocol violation and is ignored.
  assign mem_yumi = (state == WAIT) && mem_out.valid;

  // All memory-facing fields come from the holding registers, never from req_*.
  assign mem_in     = {mem_valid, wen_r, byte_r, wdata_r, mem_yumi};
  assign mem_flat_o = mem_in;
  assign mem_addr_o = addr_r;

  assign stall_o = (req_valid_i && !req_ready_o) || (state != IDLE);

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  logic err_r;
  assign misaligned = !req_byte_i && (req_addr_i[1:0] != 2'b00);
  assign resp_err_o = err_r;
`else
  assign resp_err_o = 1'b0;
`endif

  // Request FSM: latches the op in IDLE, handshakes in REQ/WAIT, pulses in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      mem_valid    <= 1'b0;
      wen_r        <= 1'b0;
      byte_r       <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      err_r        <= 1'b0;
`endif
    end else begin
      resp_valid_o <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      err_r        <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            wen_r       <= req_wen_i;
            byte_r      <= req_byte_i;
            addr_r      <= req_addr_i;
            wdata_r     <= req_wdata_i;
            req_ready_o <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
            if (misaligned) begin
              // Answer locally with an error; the memory never sees this op.
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_rdata_o <= '0;
              err_r        <= 1'b1;
            end else begin
              state     <= REQ;
              mem_valid <= 1'b1;
            end
`else
            state     <= REQ;
            mem_valid <= 1'b1;
`endif
          end
        end
        REQ: begin
          // Hold valid and all fields stable until the memory takes them.
          if (mem_out.yumi) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_out.valid) begin
            resp_rdata_o <= wen_r ? 32'h0 : mem_out.read_data;
            resp_valid_o <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          // Not ready here: this cycle lets the memory return to its idle state.
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          mem_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
